// File: rtl/hazard_sb_unit.sv
// hazard_sb_unit: RV32I forwarding/hazard control with dmem-wait freeze, watchdog and perf counters
module hazard_sb_unit #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_d,
    input  logic [31:0]      inst_x,
    input  logic [31:0]      inst_m,
    input  logic [31:0]      inst_w,
    input  logic             dmem_ready,
    input  logic             branch_taken_x,
    output logic [1:0]       selA_fwd,
    output logic [1:0]       selB_fwd,
    output logic [1:0]       sel_sw,
    output logic             selA_d,
    output logic             selB_d,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_x,
    output logic             freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_TOUT} state_t;

    state_t        state, state_n;
    logic [WW-1:0] wait_cnt, wait_cnt_n;
    logic          mem_err_n;

    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {OP_R, OP_ST, OP_BR};
    endfunction

    logic [6:0] op_d, op_x, op_m, op_w;
    logic [4:0] rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_m, rd_w;
    logic       m_src, w_src, mem_m, load_use;
    logic       unused_bits;

    assign op_d  = inst_d[6:0];
    assign op_x  = inst_x[6:0];
    assign op_m  = inst_m[6:0];
    assign op_w  = inst_w[6:0];
    assign rs1_d = inst_d[19:15];
    assign rs2_d = inst_d[24:20];
    assign rs1_x = inst_x[19:15];
    assign rs2_x = inst_x[24:20];
    assign rd_x  = inst_x[11:7];
    assign rd_m  = inst_m[11:7];
    assign rd_w  = inst_w[11:7];
    assign unused_bits = ^{inst_d[31:25], inst_d[14:7], inst_x[31:25], inst_x[14:12],
                           inst_m[31:12], inst_w[31:12]};

    // a load in M has no data yet; its consumer is covered by the load-use bubble
    assign m_src = writes_rd(op_m) && op_m != OP_LD && rd_m != 5'd0;
    assign w_src = writes_rd(op_w) && rd_w != 5'd0;
    assign mem_m = op_m == OP_LD || op_m == OP_ST;

    assign selA_fwd = (m_src && rd_m == rs1_x) ? 2'd1 : (w_src && rd_w == rs1_x) ? 2'd2 : 2'd0;
    assign selB_fwd = (m_src && rd_m == rs2_x) ? 2'd1 : (w_src && rd_w == rs2_x) ? 2'd2 : 2'd0;
    assign sel_sw   = op_x == OP_ST ? selB_fwd : 2'd0;
    assign selA_d   = w_src && uses_rs1(op_d) && rd_w == rs1_d;
    assign selB_d   = w_src && uses_rs2(op_d) && rd_w == rs2_d;

    assign load_use = op_x == OP_LD && rd_x != 5'd0 &&
                      ((uses_rs1(op_d) && rs1_d == rd_x) || (uses_rs2(op_d) && rs2_d == rd_x));

    // the TOUT cycle drops freeze once so the stuck access retires
    assign freeze  = mem_m && !dmem_ready && state != ST_TOUT;
    assign flush_d = !freeze && branch_taken_x;
    assign flush_x = !freeze && (branch_taken_x || load_use);
    assign stall_f = !freeze && !branch_taken_x && load_use;
    assign stall_d = stall_f;

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        mem_err_n  = mem_err;
        if (state == ST_RUN) begin
            if (mem_m && !dmem_ready) begin
                state_n    = ST_WAIT;
                wait_cnt_n = WW'(1);
            end
        end else if (state == ST_WAIT) begin
            if (dmem_ready) begin
                state_n = ST_RUN;
            end else if (wait_cnt == WW'(WAIT_MAX)) begin
                state_n   = ST_TOUT;
                mem_err_n = 1'b1;
            end else begin
                wait_cnt_n = wait_cnt + WW'(1);
            end
        end else begin
            state_n = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            wait_cnt   <= '0;
            mem_err    <= 1'b0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            mem_err  <= mem_err_n;
            if ((freeze || stall_d) && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_x && !freeze && !(&bubble_cnt))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_sb_unit.sv
// tb_hazard_sb_unit: directed test-plan cases plus randomized pipeline traffic vs a behavioural model
module tb_hazard_sb_unit;
    localparam int CW = 5;
    localparam int WM = 4;
    localparam int LIM = (1 << CW) - 1;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0, rst = 1'b1;
    logic [31:0]   inst_d = NOP, inst_x = NOP, inst_m = NOP, inst_w = NOP;
    logic          dmem_ready = 1'b1, branch_taken_x = 1'b0;
    logic [1:0]    selA_fwd, selB_fwd, sel_sw;
    logic          selA_d, selB_d, stall_f, stall_d, flush_d, flush_x, freeze, mem_err;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    int checks = 0, failures = 0;
    int m_run = 0, m_sc = 0, m_bc = 0;
    bit m_tout = 0, m_err = 0;
    bit e_fz, e_st, e_fd, e_fx;

    hazard_sb_unit #(.CNT_W(CW), .WAIT_MAX(WM)) dut (
        .clk(clk), .rst(rst), .inst_d(inst_d), .inst_x(inst_x), .inst_m(inst_m), .inst_w(inst_w),
        .dmem_ready(dmem_ready), .branch_taken_x(branch_taken_x),
        .selA_fwd(selA_fwd), .selB_fwd(selB_fwd), .sel_sw(sel_sw), .selA_d(selA_d), .selB_d(selB_d),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_x(flush_x),
        .freeze(freeze), .mem_err(mem_err), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit wr(input logic [6:0] op);
        case (op)
            R, I, LD, JAL, JALR, LUI, AUIPC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit u1(input logic [6:0] op);
        case (op)
            LUI, AUIPC, JAL: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit u2(input logic [6:0] op);
        case (op)
            R, ST, BR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // where X should read register r from: M result, W result, or the register file
    function automatic logic [1:0] src(input logic [31:0] m, input logic [31:0] w, input logic [4:0] r);
        if (r != 0 && wr(m[6:0]) && m[6:0] != LD && m[11:7] == r) return 2'd1;
        if (r != 0 && wr(w[6:0]) && w[11:7] == r) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h0, rs2, rs1, 3'h0, rd, op};
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [6:0] op;
        case ($urandom_range(0, 9))
            0: op = R;  1: op = I;    2: op = LD;  3: op = ST;    4: op = BR;
            5: op = JAL; 6: op = JALR; 7: op = LUI; 8: op = AUIPC; default: op = I;
        endcase
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
                5'($urandom_range(0, 3)), op};
    endfunction

    task automatic apply(input logic [31:0] d, input logic [31:0] x, input logic [31:0] m,
                         input logic [31:0] w, input logic rdy, input logic br);
        bit lu;
        inst_d = d; inst_x = x; inst_m = m; inst_w = w;
        dmem_ready = rdy; branch_taken_x = br;
        @(negedge clk);
        lu = x[6:0] == LD && x[11:7] != 0 &&
             ((u1(d[6:0]) && d[19:15] == x[11:7]) || (u2(d[6:0]) && d[24:20] == x[11:7]));
        e_fz = (m[6:0] == LD || m[6:0] == ST) && !rdy && !m_tout;
        e_fd = !e_fz && br;
        e_fx = !e_fz && (br || lu);
        e_st = !e_fz && !br && lu;
        chk("freeze", freeze, e_fz);
        chk("stall_f", stall_f, e_st);
        chk("stall_d", stall_d, e_st);
        chk("flush_d", flush_d, e_fd);
        chk("flush_x", flush_x, e_fx);
        chk("selA_fwd", selA_fwd, src(m, w, x[19:15]));
        chk("selB_fwd", selB_fwd, src(m, w, x[24:20]));
        chk("sel_sw", sel_sw, x[6:0] == ST ? src(m, w, x[24:20]) : 2'd0);
        chk("selA_d", selA_d, d[19:15] != 0 && wr(w[6:0]) && u1(d[6:0]) && w[11:7] == d[19:15]);
        chk("selB_d", selB_d, d[24:20] != 0 && wr(w[6:0]) && u2(d[6:0]) && w[11:7] == d[24:20]);
        chk("mem_err", mem_err, m_err);
        chk("stall_cnt", stall_cnt, m_sc);
        chk("bubble_cnt", bubble_cnt, m_bc);
    endtask

    task automatic tick();
        bit nt = 0;
        @(posedge clk);
        if (e_fz || e_st) m_sc = (m_sc < LIM) ? m_sc + 1 : LIM;
        if (e_fx) m_bc = (m_bc < LIM) ? m_bc + 1 : LIM;
        if (e_fz) begin
            m_run++;
            if (m_run == WM + 1) begin
                nt = 1; m_err = 1; m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_tout = nt;
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        m_run = 0; m_tout = 0; m_err = 0; m_sc = 0; m_bc = 0;
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [31:0] add5, sub6, lw7, add8, sw9, w9, wz, cd, cx, cm, cw;
        logic cbr, rdy;
        add5 = mk(R, 5, 1, 2);  sub6 = mk(R, 6, 5, 5);
        lw7  = mk(LD, 7, 1, 0); add8 = mk(R, 8, 7, 3);
        sw9  = mk(ST, 4, 2, 9); w9 = mk(I, 9, 1, 0); wz = mk(I, 0, 1, 0);
        reset_dut();
        apply(NOP, NOP, NOP, NOP, 1, 0);
        chk("rst_stall_cnt", stall_cnt, 0); chk("rst_bubble_cnt", bubble_cnt, 0); chk("rst_err", mem_err, 0);
        tick();
        apply(NOP, sub6, add5, NOP, 1, 0);
        chk("rr_m_a", selA_fwd, 1); chk("rr_m_b", selB_fwd, 1); tick();
        apply(NOP, sub6, NOP, add5, 1, 0);
        chk("rr_w_a", selA_fwd, 2); chk("rr_w_b", selB_fwd, 2); tick();
        reset_dut();
        apply(add8, lw7, NOP, NOP, 1, 0);
        chk("lu_stall_f", stall_f, 1); chk("lu_stall_d", stall_d, 1); chk("lu_flush_x", flush_x, 1);
        chk("lu_bub0", bubble_cnt, 0); tick();
        apply(add8, NOP, lw7, NOP, 1, 0);
        chk("lu_bub1", bubble_cnt, 1); chk("lu_nostall", stall_d, 0); tick();
        apply(NOP, add8, NOP, lw7, 1, 0);
        chk("lu_wfwd", selA_fwd, 2); tick();
        apply(add8, lw7, NOP, NOP, 1, 1);
        chk("br_flush_d", flush_d, 1); chk("br_flush_x", flush_x, 1); chk("br_stall_d", stall_d, 0); tick();
        apply(NOP, sw9, w9, NOP, 1, 0);
        chk("sw_fwd", sel_sw, 1); tick();
        apply(NOP, sw9, wz, NOP, 1, 0);
        chk("sw_x0", sel_sw, 0); tick();
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            apply(NOP, NOP, lw7, NOP, 0, 0); chk("wait3_fz", freeze, 1); tick();
        end
        apply(NOP, NOP, lw7, NOP, 1, 0); chk("wait3_done", freeze, 0); tick();
        apply(NOP, NOP, NOP, NOP, 1, 0);
        chk("wait3_cnt", stall_cnt, 3); chk("wait3_err", mem_err, 0); tick();
        reset_dut();
        for (int k = 0; k < WM + 1; k++) begin
            apply(NOP, NOP, lw7, NOP, 0, 0); chk("tout_fz", freeze, 1); tick();
        end
        apply(NOP, NOP, lw7, NOP, 0, 0);
        chk("tout_low", freeze, 0); chk("tout_err", mem_err, 1); tick();
        apply(NOP, NOP, lw7, NOP, 0, 0);
        chk("tout_refz", freeze, 1); chk("tout_err_hold", mem_err, 1); tick();
        apply(NOP, NOP, lw7, NOP, 0, 0);
        reset_dut();
        apply(NOP, NOP, lw7, NOP, 0, 0);
        chk("rst_mid_err", mem_err, 0); chk("rst_mid_cnt", stall_cnt, 0); chk("rst_mid_fz", freeze, 1); tick();
        apply(NOP, NOP, lw7, NOP, 1, 0); chk("rst_mid_rdy", freeze, 0); tick();
        reset_dut();
        cd = NOP; cx = NOP; cm = NOP; cw = NOP; cbr = 0; e_fz = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!e_fz) begin
                cd = rnd_inst(); cx = rnd_inst(); cm = rnd_inst(); cw = rnd_inst();
                cbr = ($urandom_range(0, 7) == 0);
                rdy = $urandom_range(0, 1) == 1;
            end else begin
                rdy = $urandom_range(0, 99) < 35;
            end
            apply(cd, cx, cm, cw, rdy, cbr);
            if ($urandom_range(0, 299) == 0) reset_dut();
            else tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_sb_unit.md
# hazard_sb_unit

Parametrised forwarding/hazard controller for the 5-stage RV32I pipeline, next generation of the combinational forwarding control. It adds a data-memory handshake (variable-latency loads/stores freeze the whole pipeline), a wait watchdog with a sticky error flag, branch-flush priority, and saturating stall/bubble performance counters. It sits beside the datapath, decodes the D/X/M/W instruction words, and drives bypass muxes and stage enables.

## Interface
- `CNT_W`, 16: width of each performance counter.
- `WAIT_MAX`, 64: maximum freeze cycles per memory access before timeout (≥1).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `inst_d`, `inst_x`, `inst_m`, `inst_w` in 32 each: instruction words in D, X, M, W; NOP = 32'h00000013.
- `dmem_ready` in 1: data memory has completed the access of the instruction in M.
- `branch_taken_x` in 1: branch/jump resolved taken in X; D and X are to be killed.
- `selA_fwd`, `selB_fwd` out 2: X operand bypass; 0 = register file, 1 = M result, 2 = W result.
- `sel_sw` out 2: store-data bypass for X; same encoding.
- `selA_d`, `selB_d` out 1: W→D write-through for register-file reads.
- `stall_f`, `stall_d` out 1: hold PC and IF/ID.
- `flush_d` out 1: load NOP into IF/ID.
- `flush_x` out 1: load NOP into ID/EX (bubble).
- `freeze` out 1: hold every pipeline register, including EX/MEM and MEM/WB.
- `mem_err` out 1: sticky watchdog timeout flag.
- `stall_cnt`, `bubble_cnt` out CNT_W each: saturating counters.

## Operation
- Opcode classes:
  - writes_rd: R 0110011, I-ALU 0010011, LOAD 0000011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - uses_rs1: every opcode except LUI, AUIPC and JAL.
  - uses_rs2: R, STORE 0100011, BRANCH 1100011.
  - mem_op: LOAD or STORE.
  - A register match never counts when the register is x0.
- X bypass, per operand:
  - M hit (M writes_rd, not LOAD, rd_m == rs_x) → 1.
  - Else W hit (W writes_rd, rd_w == rs_x) → 2.
  - Else → 0.
  - M has priority over W.
  - A LOAD in M never forwards from M; that case is covered by the load-use stall.
- `sel_sw`: the X bypass rule applied to rs2_x, only when X is a STORE; otherwise 0.
- `selA_d`/`selB_d`: 1 when W writes_rd and rd_w == rs1_d/rs2_d with the matching uses_rs bit.
- Load-use: X is a LOAD, rd_x ≠ 0, and D uses the matching rs → `stall_f` = `stall_d` = `flush_x` = 1.
- Branch: `branch_taken_x` → `flush_d` = `flush_x` = 1, `stall_f` = `stall_d` = 0. Load-use is suppressed because D is killed.
- Memory wait: `freeze` = mem_op in M & !`dmem_ready` & state == RUN/WAIT & !timeout.
- While `freeze` is 1, all other control outputs are forced to 0 and the bypass selects stay at their combinational values (inputs are stable).
- Priority: freeze > branch flush > load-use.
- FSM:
  - RUN: mem_op in M & !`dmem_ready` → WAIT, `wait_cnt` ← 1.
  - WAIT:
    - `dmem_ready` → RUN.
    - Else if `wait_cnt` == WAIT_MAX → TOUT, `mem_err` ← 1.
    - Else `wait_cnt` += 1.
  - TOUT: `freeze` = 0 for exactly this cycle so the access retires, then → RUN.
  - `mem_err` is cleared only by `rst`.
- Counters (saturate at 2^CNT_W − 1):
  - `stall_cnt` += 1 on every cycle with `freeze` | `stall_d`.
  - `bubble_cnt` += 1 on every cycle with `flush_x` & !`freeze`.

## Timing
- All hazard/bypass outputs are combinational from same-cycle inputs and state; no added latency.
- Load-use costs exactly 1 bubble; the dependent instruction gets value via W bypass (sel=2) the cycle after.
- Access with `dmem_ready` high in first M cycle: zero freeze cycles. Ready after k cycles: `freeze` is high for exactly k cycles.
- Timeout: `freeze` is high for WAIT_MAX+1 consecutive cycles, then low in the TOUT cycle; `mem_err` is visible from the TOUT cycle onward.
- Back-to-back mem ops: WAIT → RUN on ready; the next M op re-enters WAIT the following cycle if not ready.
- Reset (including mid-WAIT): state = RUN, `wait_cnt` = 0, `mem_err` = 0, both counters = 0. Combinational outputs follow the inputs immediately.

## Test plan
- R→R chain: `add x5,x1,x2` in M, `sub x6,x5,x5` in X → `selA_fwd` = `selB_fwd` = 1. With the same x5 writer in W instead of M → both 2.
- `lw x7,0(x1)` in X, `add x8,x7,x3` in D → `stall_f`/`stall_d`/`flush_x` = 1 for one cycle, `bubble_cnt` 0→1; next cycle the add in X gets `selA_fwd` = 2.
- Same load-use plus `branch_taken_x` = 1 → `flush_d` = `flush_x` = 1, `stall_d` = 0.
- `sw x9,4(x2)` in X, x9 writer in M → `sel_sw` = 1. Writer rd = x0 → `sel_sw` = 0.
- LOAD in M with `dmem_ready` low for 3 cycles → `freeze` high 3 cycles, `stall_cnt` = 3, `mem_err` = 0.
- WAIT_MAX = 4, `dmem_ready` stuck low → `freeze` high 5 cycles then low 1, `mem_err` = 1 and held. Assert `rst` mid-WAIT → all state cleared the next cycle.
